// File: rtl/array_fill_engine.sv
// Registered element array with broadcast, shift-in and FSM-driven sequential fill.
// Optional per-element parity output is enabled by defining ARRAY_FILL_PARITY_EN.
module array_fill_engine #(
    parameter int              WIDTH     = 1,
    parameter int              DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [IDX_W-1:0] o_idx,
`ifdef ARRAY_FILL_PARITY_EN
    output logic             o_par [DEPTH],
`endif
    output logic [WIDTH-1:0] o_a [DEPTH]
);

    // Handshake: a command transfers on a rising edge where i_valid && o_ready.
    // o_ready is low for the whole fill; anything offered then is dropped.
    localparam logic [1:0]       OP_BCAST = 2'b01;
    localparam logic [1:0]       OP_SEQ   = 2'b10;
    localparam logic [1:0]       OP_SHIFT = 2'b11;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             r_done;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_fill;
    logic [WIDTH-1:0] r_a    [DEPTH];
    logic [WIDTH-1:0] w_src  [DEPTH];
    logic [WIDTH-1:0] w_nxt  [DEPTH];
    logic             w_we   [DEPTH];
`ifdef ARRAY_FILL_PARITY_EN
    logic             r_par  [DEPTH];
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_valid && i_op == OP_SEQ) w_next = S_FILL;
            S_FILL: if (r_idx == LAST_IDX) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready  = (r_state == S_IDLE);
        o_busy   = (r_state == S_FILL);
        w_accept = o_ready && i_valid;
    end

    // Shift source: element k takes element k-1, element 0 takes the operand.
    always_comb begin
        w_src[0] = i_a;
        for (int k = 1; k < DEPTH; k++) w_src[k] = r_a[k-1];
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_we[k]  = 1'b0;
            w_nxt[k] = r_a[k];
            if (w_accept && i_op == OP_BCAST) begin
                w_we[k]  = 1'b1;
                w_nxt[k] = i_a;
            end else if (w_accept && i_op == OP_SHIFT) begin
                w_we[k]  = 1'b1;
                w_nxt[k] = w_src[k];
            end else if (r_state == S_FILL && r_idx == IDX_W'(k)) begin
                w_we[k]  = 1'b1;
                w_nxt[k] = r_fill;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_done <= 1'b0;
            r_idx  <= '0;
            r_fill <= RESET_VAL;
            for (int k = 0; k < DEPTH; k++) begin
                r_a[k] <= RESET_VAL;
`ifdef ARRAY_FILL_PARITY_EN
                r_par[k] <= ^RESET_VAL;
`endif
            end
        end else begin
            r_done <= (r_state == S_FILL) && (r_idx == LAST_IDX);
            if (w_accept && i_op == OP_SEQ) begin
                r_fill <= i_a;
                r_idx  <= '0;
            end else if (r_state == S_FILL) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (w_we[k]) begin
                    r_a[k] <= w_nxt[k];
`ifdef ARRAY_FILL_PARITY_EN
                    r_par[k] <= ^w_nxt[k];
`endif
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_idx  = r_idx;
    assign o_a    = r_a;
`ifdef ARRAY_FILL_PARITY_EN
    assign o_par  = r_par;
`endif

endmodule
